// File: rtl/a25_dmem_responder_if.sv
// Data-memory request/response bundle between a pipeline (master) and the
// a25_dmem_responder (slave). Names are from the responder's point of view.
interface a25_dmem_responder_if;
  logic [31:0] i_daddress;
  logic        i_daddress_valid;
  logic        i_write_enable;
  logic [3:0]  i_byte_enable;
  logic [31:0] i_write_data;
  logic        i_exclusive;
  logic        o_mem_stall;
  logic [31:0] o_wb_read_data;
  logic        o_wb_read_data_valid;
  logic        o_bus_error;

  modport slave (
    input  i_daddress, i_daddress_valid, i_write_enable,
    input  i_byte_enable, i_write_data, i_exclusive,
    output o_mem_stall, o_wb_read_data, o_wb_read_data_valid, o_bus_error
  );

  modport master (
    output i_daddress, i_daddress_valid, i_write_enable,
    output i_byte_enable, i_write_data, i_exclusive,
    input  o_mem_stall, o_wb_read_data, o_wb_read_data_valid, o_bus_error
  );
endinterface

// File: rtl/a25_dmem_responder.sv
// Fixed-latency data-memory responder with byte-masked stores, a single
// exclusive-access reservation and out-of-range bus-error reporting.
module a25_dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  a25_dmem_responder_if.slave     dmem
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]    r_state;
  logic [3:0]    r_cnt;
  logic [29:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_we;
  logic          r_excl;

  logic          r_resv_valid;
  logic [AW-1:0] r_resv_idx;

  logic          r_rvalid;
  logic          r_berr;
  logic          r_use_ram;
  logic [31:0]   r_result;
  logic [31:0]   r_ram_q;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_complete;
  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_resv_hit;
  logic          w_mem_wr;
  logic          w_mem_rd;
  logic          w_stall;
  logic          w_unused_addr_lsb;

  // Byte offset bits never select anything in a word-organised memory.
  assign w_unused_addr_lsb = ^dmem.i_daddress[1:0];

  assign w_accept   = (r_state == ST_IDLE) && dmem.i_daddress_valid;
  assign w_complete = (r_state == ST_BUSY) && (r_cnt == 4'd0);
  assign w_idx      = r_addr[AW-1:0];
  assign w_oor      = |r_addr[29:AW];
  assign w_resv_hit = r_resv_valid && (r_resv_idx == w_idx);

  // A failed store-exclusive must leave memory untouched.
  assign w_mem_wr = w_complete && !w_oor && r_we && (!r_excl || w_resv_hit);
  assign w_mem_rd = w_complete && !w_oor && !r_we;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_stall = 1'b0;
    if (w_accept)
      w_stall = 1'b1;
    else if ((r_state == ST_BUSY) && (r_cnt != 4'd0))
      w_stall = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
      r_excl  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (dmem.i_daddress_valid) begin
            r_addr  <= dmem.i_daddress[31:2];
            r_wdata <= dmem.i_write_data;
            r_be    <= dmem.i_byte_enable;
            r_we    <= dmem.i_write_enable;
            r_excl  <= dmem.i_exclusive;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= ST_BUSY;
          end
        end
        default: begin
          if (r_cnt != 4'd0)
            r_cnt <= r_cnt - 4'd1;
          else
            r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Exclusive monitor: out-of-range accesses never touch it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resv_valid <= 1'b0;
      r_resv_idx   <= '0;
    end else if (w_complete && !w_oor) begin
      if (!r_we && r_excl) begin
        r_resv_valid <= 1'b1;
        r_resv_idx   <= w_idx;
      end else if (r_we && r_excl) begin
        r_resv_valid <= 1'b0;
      end else if (r_we && w_resv_hit) begin
        r_resv_valid <= 1'b0;
      end
    end
  end

  // NOTE: the storage array has no reset so it maps onto a plain
  // synchronous single-port RAM; reset only gates what reaches it.
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b])
          r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
    if (w_mem_rd)
      r_ram_q <= r_mem[w_idx];
  end

  // Result path: loads return the RAM output register, everything else a
  // held status word; both are only refreshed by a strobing completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rvalid  <= 1'b0;
      r_berr    <= 1'b0;
      r_use_ram <= 1'b0;
      r_result  <= 32'h0;
    end else begin
      r_rvalid <= w_complete && (!r_we || r_excl);
      r_berr   <= w_complete && w_oor;
      if (w_complete) begin
        if (w_oor) begin
          if (!r_we || r_excl) begin
            r_use_ram <= 1'b0;
            r_result  <= 32'h0;
          end
        end else if (!r_we) begin
          r_use_ram <= 1'b1;
        end else if (r_excl) begin
          r_use_ram <= 1'b0;
          r_result  <= w_resv_hit ? 32'h0 : 32'h1;
        end
      end
    end
  end

  assign dmem.o_mem_stall          = w_stall;
  assign dmem.o_wb_read_data       = r_use_ram ? r_ram_q : r_result;
  assign dmem.o_wb_read_data_valid = r_rvalid;
  assign dmem.o_bus_error          = r_berr;

endmodule

// File: tb/tb_a25_dmem_responder.sv
// Directed bench for a25_dmem_responder (DEPTH_WORDS=256, LATENCY=2).
module tb_a25_dmem_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  int          n_stall;
  logic        res_valid, res_berr, post_valid, post_berr;
  logic [31:0] res_data;

  a25_dmem_responder_if bus ();

  a25_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .dmem  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request: drive, count stall cycles, then sample the cycle after the
  // completion edge and the cycle after that.
  task automatic do_req(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, input logic ex);
    @(negedge clk);
    bus.i_daddress       = addr;
    bus.i_write_enable   = we;
    bus.i_byte_enable    = be;
    bus.i_write_data     = wd;
    bus.i_exclusive      = ex;
    bus.i_daddress_valid = 1'b1;
    #1;
    n_stall = 0;
    while (bus.o_mem_stall === 1'b1 && n_stall < 20) begin
      n_stall++;
      @(negedge clk);
      bus.i_daddress_valid = 1'b0;
      bus.i_write_data     = ~wd;
      #1;
    end
    @(negedge clk); #1;
    res_valid = bus.o_wb_read_data_valid;
    res_berr  = bus.o_bus_error;
    res_data  = bus.o_wb_read_data;
    @(negedge clk); #1;
    post_valid = bus.o_wb_read_data_valid;
    post_berr  = bus.o_bus_error;
  endtask

  task automatic access(input string tag, input logic [31:0] addr, input logic we,
                        input logic [3:0] be, input logic [31:0] wd, input logic ex,
                        input logic exp_valid, input logic [31:0] exp_data, input logic exp_berr);
    do_req(addr, we, be, wd, ex);
    check({tag, ".stall"}, n_stall, 32'd2);
    check({tag, ".valid"}, {31'd0, res_valid}, {31'd0, exp_valid});
    check({tag, ".berr"}, {31'd0, res_berr}, {31'd0, exp_berr});
    if (exp_valid) check({tag, ".data"}, res_data, exp_data);
    check({tag, ".valid_1cyc"}, {31'd0, post_valid}, 32'd0);
    check({tag, ".berr_1cyc"}, {31'd0, post_berr}, 32'd0);
  endtask

  initial begin
    bus.i_daddress = '0; bus.i_daddress_valid = 1'b0; bus.i_write_enable = 1'b0;
    bus.i_byte_enable = '0; bus.i_write_data = '0; bus.i_exclusive = 1'b0;

    // Reset state; stall still reflects IDLE & valid while in reset.
    repeat (2) @(negedge clk);
    #1;
    check("rst.stall", {31'd0, bus.o_mem_stall}, 32'd0);
    check("rst.data", bus.o_wb_read_data, 32'h0);
    check("rst.valid", {31'd0, bus.o_wb_read_data_valid}, 32'd0);
    check("rst.berr", {31'd0, bus.o_bus_error}, 32'd0);
    bus.i_daddress_valid = 1'b1; #1;
    check("rst.stall_req", {31'd0, bus.o_mem_stall}, 32'd1);
    bus.i_daddress_valid = 1'b0;
    @(negedge clk); reset = 1'b1;

    // Basic store then load.
    access("st10", 32'h10, 1, 4'hF, 32'hDEADBEEF, 0, 0, 32'h0, 0);
    access("ld10", 32'h10, 0, 4'hF, 32'h0, 0, 1, 32'hDEADBEEF, 0);
    @(negedge clk); #1;
    check("hold.data", bus.o_wb_read_data, 32'hDEADBEEF);

    // Byte-lane merge and empty byte mask.
    access("st20", 32'h20, 1, 4'hF, 32'h12345678, 0, 0, 32'h0, 0);
    access("st20b", 32'h22, 1, 4'b0001, 32'h000000AA, 0, 0, 32'h0, 0);
    access("ld20", 32'h20, 0, 4'h0, 32'h0, 0, 1, 32'h123456AA, 0);
    access("st20z", 32'h20, 1, 4'b0000, 32'hFFFFFFFF, 0, 0, 32'h0, 0);
    access("ld20z", 32'h20, 0, 4'h0, 32'h0, 0, 1, 32'h123456AA, 0);

    // Exclusive pair, then a repeat that must fail.
    access("st40", 32'h40, 1, 4'hF, 32'h11111111, 0, 0, 32'h0, 0);
    access("ldx40", 32'h40, 0, 4'h0, 32'h0, 1, 1, 32'h11111111, 0);
    access("stx40a", 32'h40, 1, 4'hF, 32'h22222222, 1, 1, 32'h0, 0);
    access("stx40b", 32'h40, 1, 4'hF, 32'h33333333, 1, 1, 32'h1, 0);
    access("ld40a", 32'h40, 0, 4'h0, 32'h0, 0, 1, 32'h22222222, 0);

    // Plain store to the reserved word breaks the reservation.
    access("ldx40c", 32'h40, 0, 4'h0, 32'h0, 1, 1, 32'h22222222, 0);
    access("st40c", 32'h40, 1, 4'hF, 32'h44444444, 0, 0, 32'h0, 0);
    access("stx40c", 32'h40, 1, 4'hF, 32'h55555555, 1, 1, 32'h1, 0);
    access("ld40c", 32'h40, 0, 4'h0, 32'h0, 0, 1, 32'h44444444, 0);

    // Plain loads keep the reservation; a different index fails.
    access("ldx40d", 32'h40, 0, 4'h0, 32'h0, 1, 1, 32'h44444444, 0);
    access("ld40d", 32'h40, 0, 4'h0, 32'h0, 0, 1, 32'h44444444, 0);
    access("stx40d", 32'h40, 1, 4'hF, 32'h66666666, 1, 1, 32'h0, 0);
    access("ldx40e", 32'h40, 0, 4'h0, 32'h0, 1, 1, 32'h66666666, 0);
    access("stx44e", 32'h44, 1, 4'hF, 32'h77777777, 1, 1, 32'h1, 0);

    // Out-of-range accesses and the last in-range word.
    access("st0", 32'h0, 1, 4'hF, 32'hCAFEF00D, 0, 0, 32'h0, 0);
    access("ld400", 32'h400, 0, 4'h0, 32'h0, 0, 1, 32'h0, 1);
    access("st400", 32'h400, 1, 4'hF, 32'hBAD0BAD0, 0, 0, 32'h0, 1);
    access("ld0", 32'h0, 0, 4'h0, 32'h0, 0, 1, 32'hCAFEF00D, 0);
    access("st_hi", 32'h80000010, 1, 4'hF, 32'h0BADF00D, 0, 0, 32'h0, 1);
    access("ld10b", 32'h10, 0, 4'h0, 32'h0, 0, 1, 32'hDEADBEEF, 0);
    access("st3fc", 32'h3FC, 1, 4'hF, 32'hA5A55A5A, 0, 0, 32'h0, 0);
    access("ld3fc", 32'h3FC, 0, 4'h0, 32'h0, 0, 1, 32'hA5A55A5A, 0);
    access("ldx40f", 32'h40, 0, 4'h0, 32'h0, 1, 1, 32'h66666666, 0);
    access("ldx440", 32'h440, 0, 4'h0, 32'h0, 1, 1, 32'h0, 1);
    access("stx440", 32'h440, 1, 4'hF, 32'h12121212, 1, 1, 32'h0, 1);
    access("stx40f", 32'h40, 1, 4'hF, 32'h88888888, 1, 1, 32'h0, 0);

    // Request held through the completion cycle is accepted only afterwards.
    @(negedge clk);
    bus.i_daddress = 32'h10; bus.i_write_enable = 1'b0; bus.i_exclusive = 1'b0;
    bus.i_daddress_valid = 1'b1;
    @(negedge clk); #1;
    check("b2b.busy", {31'd0, bus.o_mem_stall}, 32'd1);
    @(negedge clk); #1;
    check("b2b.complete", {31'd0, bus.o_mem_stall}, 32'd0);
    @(negedge clk); #1;
    check("b2b.reaccept", {31'd0, bus.o_mem_stall}, 32'd1);
    check("b2b.valid", {31'd0, bus.o_wb_read_data_valid}, 32'd1);
    check("b2b.data", bus.o_wb_read_data, 32'hDEADBEEF);
    bus.i_daddress_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of a store abandons it and drops the reservation.
    access("ldx40g", 32'h40, 0, 4'h0, 32'h0, 1, 1, 32'h88888888, 0);
    @(negedge clk);
    bus.i_daddress = 32'h40; bus.i_write_enable = 1'b1; bus.i_byte_enable = 4'hF;
    bus.i_write_data = 32'h77777777; bus.i_exclusive = 1'b0; bus.i_daddress_valid = 1'b1;
    @(negedge clk);
    bus.i_daddress_valid = 1'b0;
    reset = 1'b0; #1;
    check("mid.stall", {31'd0, bus.o_mem_stall}, 32'd0);
    check("mid.data", bus.o_wb_read_data, 32'h0);
    repeat (3) begin
      @(negedge clk); #1;
      check("mid.valid", {31'd0, bus.o_wb_read_data_valid}, 32'd0);
      check("mid.berr", {31'd0, bus.o_bus_error}, 32'd0);
    end
    reset = 1'b1;
    access("ld40h", 32'h40, 0, 4'h0, 32'h0, 0, 1, 32'h88888888, 0);
    access("stx40h", 32'h40, 1, 4'hF, 32'h99999999, 1, 1, 32'h1, 0);
    access("ld40i", 32'h40, 0, 4'h0, 32'h0, 0, 1, 32'h88888888, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
